// File: rtl/fe_pkg.sv
// Shared field constants and controller state encoding for the GF(2^255-19) blocks.
package fe_pkg;

    localparam int unsigned FE_BITS = 255;

    // p = 2^255 - 19
    localparam logic [FE_BITS-1:0] P = {FE_BITS{1'b1}} - 255'd18;
    localparam logic [FE_BITS-1:0] P_MINUS_2 = P - 255'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSqIssue,
        StSqWait,
        StMulIssue,
        StMulWait,
        StFinish
    } state_e;

    function automatic int unsigned top_bit(input logic [FE_BITS-1:0] v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < FE_BITS; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/femul.sv
// Three-stage modular multiplier mod 2^255-19: product, first fold, final fold plus
// conditional subtract. done rises two cycles after start and stays high until the next start.
module femul
    import fe_pkg::*;
(
    input  logic               clock,
    input  logic               start,
    input  logic [FE_BITS-1:0] a,
    input  logic [FE_BITS-1:0] b,
    output logic               done,
    output logic [FE_BITS-1:0] out
);

    logic [509:0]       prod_q;
    logic [259:0]       fold_q;
    logic [1:0]         vld_q;
    logic               done_q;
    logic [FE_BITS-1:0] out_q;

    logic [259:0] fold_d;
    logic [255:0] red_sum;
    logic [FE_BITS-1:0] out_d;

    // 2^255 == 19 (mod p), so the high part folds back in scaled by 19.
    always_comb begin
        fold_d  = {5'b0, prod_q[254:0]} + 260'(prod_q[509:255]) * 260'd19;
        red_sum = {1'b0, fold_q[254:0]} + 256'(fold_q[259:255]) * 256'd19;
        // red_sum < 2p here, so a single subtract makes it canonical.
        if (red_sum >= {1'b0, P}) begin
            out_d = 255'(red_sum - {1'b0, P});
        end else begin
            out_d = red_sum[254:0];
        end
    end

    always_ff @(posedge clock) begin
        vld_q <= {vld_q[0], start};
        if (start) begin
            prod_q <= 510'(a) * 510'(b);
            done_q <= 1'b0;
        end else if (vld_q[1]) begin
            done_q <= 1'b1;
        end
        if (vld_q[0]) fold_q <= fold_d;
        if (vld_q[1]) out_q <= out_d;
    end

    assign done = done_q;
    assign out  = out_q;

endmodule

// File: rtl/feinv.sv
// Constant-time field exponentiation in^EXP mod p (inversion by default) using one shared
// femul and left-to-right square-and-multiply.
module feinv
    import fe_pkg::*;
#(
    parameter logic [FE_BITS-1:0] EXP = P_MINUS_2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [FE_BITS-1:0] in,
    output logic               busy,
    output logic               done,
    output logic [FE_BITS-1:0] out
);

    localparam int unsigned TopBit  = top_bit(EXP);
    localparam logic [7:0]  IdxInit = 8'(TopBit - 1);

    state_e             state_q;
    logic [7:0]         idx_q;
    logic [FE_BITS-1:0] base_q;
    logic [FE_BITS-1:0] acc_q;
    logic [FE_BITS-1:0] out_q;
    logic               busy_q;
    logic               done_q;
    logic               mstart_q;
    logic               first_q;

    logic               mul_done;
    logic [FE_BITS-1:0] mul_b;
    logic [FE_BITS-1:0] mul_out;

    // Squaring uses (acc, acc); multiply steps use (acc, base).
    assign mul_b = (state_q == StMulIssue) ? base_q : acc_q;

    femul u_femul (
        .clock (clock),
        .start (mstart_q),
        .a     (acc_q),
        .b     (mul_b),
        .done  (mul_done),
        .out   (mul_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mstart_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            mstart_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q   <= in;
                        acc_q    <= in;
                        idx_q    <= IdxInit;
                        busy_q   <= 1'b1;
                        mstart_q <= 1'b1;
                        state_q  <= StSqIssue;
                    end
                end
                StSqIssue: begin
                    first_q <= 1'b1;
                    state_q <= StSqWait;
                end
                StSqWait: begin
                    // The first wait cycle may still see the previous operation's done level.
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (mul_done) begin
                        acc_q <= mul_out;
                        if (EXP[idx_q]) begin
                            mstart_q <= 1'b1;
                            state_q  <= StMulIssue;
                        end else if (idx_q != 8'd0) begin
                            idx_q    <= idx_q - 8'd1;
                            mstart_q <= 1'b1;
                            state_q  <= StSqIssue;
                        end else begin
                            state_q <= StFinish;
                        end
                    end
                end
                StMulIssue: begin
                    first_q <= 1'b1;
                    state_q <= StMulWait;
                end
                StMulWait: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (mul_done) begin
                        acc_q <= mul_out;
                        if (idx_q != 8'd0) begin
                            idx_q    <= idx_q - 8'd1;
                            mstart_q <= 1'b1;
                            state_q  <= StSqIssue;
                        end else begin
                            state_q <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    out_q   <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule
